// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings and FSM state type.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand and result handshake bundle between the issuing controller and the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [1:0]         sel;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;
  logic               flag_zero;
  logic               flag_carry;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, z, flag_zero, flag_carry
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, z, flag_zero, flag_carry
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier core: one multiplier bit per cycle, WIDTH iterations after start.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_acc
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CntW-1:0]    r_count;
  logic               w_done;

  assign w_done = (r_count == CntW'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (!w_done) begin
      // Multiplicand stays unshifted; the partial product is aligned by the count.
      if (r_mplier[0]) begin
        r_acc <= r_acc + (r_mcand << r_count);
      end
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CntW'(1);
    end
  end

  assign o_done = w_done;
  assign o_acc  = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready in and out; add/sub/xor in one edge, iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic [2*WIDTH-1:0] r_z;
  logic [2*WIDTH-1:0] w_z_next;
  logic               r_zero;
  logic               w_zero_next;
  logic               r_carry;
  logic               w_carry_next;

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_alu_z;
  logic               w_alu_carry;

  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_acc;

  assign w_a_ext = {{WIDTH{1'b0}}, bus.a};
  assign w_b_ext = {{WIDTH{1'b0}}, bus.b};

  always_comb begin
    w_alu_z     = '0;
    w_alu_carry = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        w_alu_z     = w_a_ext + w_b_ext;
        w_alu_carry = w_alu_z[WIDTH];
      end
      OP_SUB: begin
        w_alu_z     = w_a_ext - w_b_ext;
        w_alu_carry = (bus.a < bus.b);
      end
      OP_XOR: begin
        w_alu_z     = w_a_ext ^ w_b_ext;
        w_alu_carry = 1'b0;
      end
      default: begin
        w_alu_z     = '0;
        w_alu_carry = 1'b0;
      end
    endcase
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mul_start),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_done  (w_mul_done),
    .o_acc   (w_mul_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_z     <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_z     <= w_z_next;
      r_zero  <= w_zero_next;
      r_carry <= w_carry_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_z_next     = r_z;
    w_zero_next  = r_zero;
    w_carry_next = r_carry;
    w_mul_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.sel == OP_MUL) begin
            w_mul_start  = 1'b1;
            w_state_next = MUL;
          end else begin
            w_z_next     = w_alu_z;
            w_zero_next  = (w_alu_z == '0);
            w_carry_next = w_alu_carry;
            w_state_next = DONE;
          end
        end
      end
      MUL: begin
        // Result is loaded one edge after the last iteration, giving WIDTH+1 edges total.
        if (w_mul_done) begin
          w_z_next     = w_mul_acc;
          w_zero_next  = (w_mul_acc == '0);
          w_carry_next = 1'b0;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.z          = r_z;
  assign bus.flag_zero  = r_zero;
  assign bus.flag_carry = r_carry;

endmodule
